// File: rtl/decode_pipe.sv
// decode_pipe -- RV32I decode stage with a two-entry skid buffer.
//
// Accepts an instruction/PC pair under valid/ready handshaking. It extracts the
// instruction fields and the sign-extended immediate, then holds the decoded
// result in a main register plus a skid register. Because of the skid register,
// ready_o depends only on registered state and full throughput is kept under
// backpressure. flush_i squashes every held entry and any same-cycle input.
//
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to compute illegal_o at
// push time. Without it, illegal_o is constant 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valid_i/ready_o   upstream handshake; insn_i, pc_i are the payload
//   flush_i           drop all held entries and any same-cycle input
//   valid_o/ready_i   downstream handshake for the head entry
//   pc_o, insn_o      PC and raw instruction of the head entry
//   opcode_o .. shamt_o  instruction fields of the head entry
//   imm_o             sign-extended immediate of the head entry
//   illegal_o         head entry is not a legal RV32I encoding
module decode_pipe #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o
);

  if (DWIDTH != 32) begin : g_width_check
    $error("decode_pipe supports only DWIDTH = 32");
  end

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state;
  logic [AWIDTH-1:0] main_pc, skid_pc;
  logic [DWIDTH-1:0] main_insn, skid_insn;
  logic [DWIDTH-1:0] main_imm, skid_imm;
  logic              main_ill, skid_ill;

  logic              push, pop;
  logic [DWIDTH-1:0] in_imm;
  logic              in_ill;

  assign ready_o = (state != TWO) && !rst;
  assign valid_o = (state != EMPTY);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // Immediate generation at the input side, so it is stored with the entry.
  always_comb begin
    in_imm = '0;
    case (insn_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        in_imm = {{20{insn_i[31]}}, insn_i[31:20]};
      7'b0100011:
        in_imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      7'b1100011:
        in_imm = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        in_imm = {insn_i[31:12], 12'b0};
      7'b1101111:
        in_imm = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      default:
        in_imm = '0;
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic [2:0] in_f3;
  logic [6:0] in_f7;
  assign in_f3 = insn_i[14:12];
  assign in_f7 = insn_i[31:25];

  always_comb begin
    in_ill = 1'b0;
    case (insn_i[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111, 7'b1110011:
        in_ill = 1'b0;
      7'b1100111: in_ill = (in_f3 != 3'b000);
      7'b1100011: in_ill = (in_f3 == 3'b010) || (in_f3 == 3'b011);
      7'b0000011: in_ill = (in_f3 == 3'b011) || (in_f3 == 3'b110) || (in_f3 == 3'b111);
      7'b0100011: in_ill = (in_f3 > 3'b010);
      // Shift-immediates reuse funct7: SLLI needs 0, SRLI/SRAI allow 0 or 0100000.
      7'b0010011: in_ill = ((in_f3 == 3'b001) && (in_f7 != 7'b0000000)) ||
                           ((in_f3 == 3'b101) && (in_f7 != 7'b0000000) &&
                            (in_f7 != 7'b0100000));
      // Only SUB and SRA use funct7 = 0100000.
      7'b0110011: in_ill = ((in_f7 != 7'b0000000) && (in_f7 != 7'b0100000)) ||
                           ((in_f7 == 7'b0100000) && (in_f3 != 3'b000) &&
                            (in_f3 != 3'b101));
      default:    in_ill = 1'b1;
    endcase
    if (insn_i[1:0] != 2'b11) in_ill = 1'b1;
  end
`else
  assign in_ill = 1'b0;
`endif

  // Occupancy FSM and entry storage. Flush overrides push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_insn <= '0;
      main_imm  <= '0;
      main_ill  <= 1'b0;
      skid_pc   <= '0;
      skid_insn <= '0;
      skid_imm  <= '0;
      skid_ill  <= 1'b0;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_pc   <= pc_i;
            main_insn <= insn_i;
            main_imm  <= in_imm;
            main_ill  <= in_ill;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_pc   <= pc_i;
            skid_insn <= insn_i;
            skid_imm  <= in_imm;
            skid_ill  <= in_ill;
            state     <= TWO;
          end else if (push && pop) begin
            main_pc   <= pc_i;
            main_insn <= insn_i;
            main_imm  <= in_imm;
            main_ill  <= in_ill;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_pc   <= skid_pc;
            main_insn <= skid_insn;
            main_imm  <= skid_imm;
            main_ill  <= skid_ill;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Outputs come straight from the main register, so they are glitch-free.
  assign pc_o      = main_pc;
  assign insn_o    = main_insn;
  assign imm_o     = main_imm;
  assign illegal_o = main_ill;
  assign opcode_o  = main_insn[6:0];
  assign rd_o      = main_insn[11:7];
  assign funct3_o  = main_insn[14:12];
  assign rs1_o     = main_insn[19:15];
  assign rs2_o     = main_insn[24:20];
  assign funct7_o  = main_insn[31:25];
  assign shamt_o   = main_insn[24:20];

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe with a FIFO scoreboard of expected entries.
module tb_decode_pipe;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i, illegal_o;
  logic [31:0] insn_i, pc_i, pc_o, insn_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
  logic [2:0]  funct3_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] imm;
    logic        ill;
  } entry_t;

  entry_t q[$];
  int     checks = 0;
  int     errors = 0;
  int     pushes = 0;
  int     pops   = 0;
  logic   acc;

  always #5 clk = ~clk;

  decode_pipe #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .insn_i(insn_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct7_o(funct7_o), .shamt_o(shamt_o), .imm_o(imm_o), .illegal_o(illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return {{20{i[31]}}, i[31:20]};
      7'h23: return {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: return {i[31:12], 12'h000};
      7'h6F: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_ill(input logic [31:0] i);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    if (!ILL_EN) return 1'b0;
    if (i[1:0] != 2'b11) return 1'b1;
    case (i[6:0])
      7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73: return 1'b0;
      7'h67: return f3 != 3'd0;
      7'h63: return (f3 == 3'd2) || (f3 == 3'd3);
      7'h03: return (f3 == 3'd3) || (f3 >= 3'd6);
      7'h23: return f3 > 3'd2;
      7'h13: return ((f3 == 3'd1) && (f7 != 7'h00)) ||
                    ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      7'h33: return ((f7 != 7'h00) && (f7 != 7'h20)) ||
                    ((f7 == 7'h20) && (f3 != 3'd0) && (f3 != 3'd5));
      default: return 1'b1;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, sample handshakes 1 ns later,
  // then return at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic rdy, input logic fl, output logic accepted);
    entry_t e;
    valid_i = v;
    insn_i  = ins;
    pc_i    = p;
    ready_i = rdy;
    flush_i = fl;
    #1;
    if (valid_o && ready_i) begin
      check("pop_has_expected", (q.size() > 0), 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        pops++;
        $display("pop  pc=%08h insn=%08h imm=%08h ill=%0b", pc_o, insn_o, imm_o, illegal_o);
        check("pop_pc", pc_o, e.pc);
        check("pop_insn", insn_o, e.insn);
        check("pop_imm", imm_o, e.imm);
        check("pop_illegal", illegal_o, e.ill);
        check("pop_fields",
              {opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, shamt_o},
              {e.insn[6:0], e.insn[11:7], e.insn[14:12], e.insn[19:15],
               e.insn[24:20], e.insn[31:25], e.insn[24:20]});
      end
    end
    accepted = v && ready_o && !fl;
    if (accepted) begin
      e.pc   = p;
      e.insn = ins;
      e.imm  = ref_imm(ins);
      e.ill  = ref_ill(ins);
      q.push_back(e);
      pushes++;
      $display("push pc=%08h insn=%08h", p, ins);
    end
    @(posedge clk);
    if (fl) q.delete();
    @(negedge clk);
  endtask

  initial begin
    logic        cacc;
    logic [31:0] rins;
    int          guard;

    rst = 1'b1; valid_i = 1'b0; insn_i = '0; pc_i = '0; flush_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_ready_o", ready_o, 1'b0);
    check("rst_pc_o", pc_o, 32'h0);
    check("rst_imm_o", imm_o, 32'h0);
    check("rst_insn_o", insn_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // addi x1,x2,-5
    cycle(1'b1, 32'hFFB10093, 32'h100, 1'b1, 1'b0, acc);
    check("addi_valid", valid_o, 1'b1);
    check("addi_rd", rd_o, 5'd1);
    check("addi_rs1", rs1_o, 5'd2);
    check("addi_funct3", funct3_o, 3'd0);
    check("addi_imm", imm_o, 32'hFFFFFFFB);
    check("addi_pc", pc_o, 32'h100);

    // lui then beq back-to-back
    cycle(1'b1, 32'h123452B7, 32'h104, 1'b1, 1'b0, acc);
    check("lui_imm", imm_o, 32'h12345000);
    cycle(1'b1, 32'hFE000EE3, 32'h108, 1'b1, 1'b0, acc);
    check("beq_imm", imm_o, 32'hFFFFFFFC);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("drained_valid", valid_o, 1'b0);

    // Backpressure: two accepted, third refused, outputs held
    cycle(1'b1, 32'h00A00513, 32'h200, 1'b0, 1'b0, acc);
    check("bp_ready_one", ready_o, 1'b1);
    cycle(1'b1, 32'h00112023, 32'h204, 1'b0, 1'b0, acc);
    check("bp_ready_two", ready_o, 1'b0);
    check("bp_valid_two", valid_o, 1'b1);
    cycle(1'b1, 32'h0100006F, 32'h208, 1'b0, 1'b0, cacc);
    check("bp_third_refused", cacc, 1'b0);
    check("bp_held_pc", pc_o, 32'h200);
    check("bp_held_imm", imm_o, 32'h0000000A);
    guard = 0;
    while (!(cacc && q.size() == 0) && guard < 10) begin
      cycle(!cacc, 32'h0100006F, 32'h208, 1'b1, 1'b0, acc);
      if (acc) cacc = 1'b1;
      guard++;
    end
    check("bp_drain_done", (cacc && q.size() == 0), 1'b1);

    // Flush with one entry and a same-cycle valid input
    cycle(1'b1, 32'h00300193, 32'h300, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00400213, 32'h304, 1'b0, 1'b1, acc);
    check("flush1_valid", valid_o, 1'b0);
    check("flush1_ready", ready_o, 1'b1);
    // Flush with two entries held
    cycle(1'b1, 32'h00500293, 32'h308, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00600313, 32'h30C, 1'b0, 1'b0, acc);
    check("flush2_full", ready_o, 1'b0);
    cycle(1'b1, 32'h00700393, 32'h310, 1'b0, 1'b1, acc);
    check("flush2_valid", valid_o, 1'b0);
    check("flush2_ready", ready_o, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("flush_nothing_out", valid_o, 1'b0);

    // Illegal-encoding detection
    cycle(1'b1, 32'h00000000, 32'h400, 1'b1, 1'b0, acc);
    check("ill_zero", illegal_o, ILL_EN);
    cycle(1'b1, 32'h00003003, 32'h404, 1'b1, 1'b0, acc);
    check("ill_load_f3", illegal_o, ILL_EN);
    cycle(1'b1, 32'h00000013, 32'h408, 1'b1, 1'b0, acc);
    check("ill_nop", illegal_o, 1'b0);
    cycle(1'b1, 32'h40001033, 32'h40C, 1'b1, 1'b0, acc);
    check("ill_op_f7", illegal_o, ILL_EN);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // Random traffic with random backpressure
    for (int k = 0; k < 24; k++) begin
      rins = $urandom;
      if (k % 3 == 0) rins[1:0] = 2'b11;
      cycle(1'($urandom_range(0, 1)), rins, 32'h1000 + 32'(k * 4),
            1'($urandom_range(0, 1)), 1'b0, acc);
    end
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      guard++;
    end
    check("rand_drain_done", q.size(), 0);

    // Asynchronous reset with two entries held
    cycle(1'b1, 32'h00800413, 32'h500, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00900493, 32'h504, 1'b0, 1'b0, acc);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid_o", valid_o, 1'b0);
    check("arst_ready_o", ready_o, 1'b0);
    check("arst_pc_o", pc_o, 32'h0);
    check("arst_insn_o", insn_o, 32'h0);
    check("arst_imm_o", imm_o, 32'h0);
    check("arst_illegal_o", illegal_o, 1'b0);
    check("arst_fields", {opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, shamt_o}, 37'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'hFFB10093, 32'h600, 1'b1, 1'b0, acc);
    check("post_rst_valid", valid_o, 1'b1);
    check("post_rst_pc", pc_o, 32'h600);
    check("post_rst_imm", imm_o, 32'hFFFFFFFB);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("final_empty", q.size(), 0);
    check("final_valid", valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
